// File: rtl/mem_loader.sv
// mem_loader: streams words into IRAM, then DRAM, through a timed write strobe, then starts the processor.
// Optional build macro LOADER_CHECKSUM_EN: running checksum on chk_out plus a verified trailer word before RUN.
module mem_loader #(
    parameter int unsigned WR_HOLD   = 4,
    parameter logic [8:0]  ADDR_BASE = 9'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [8:0]  addr_ext,
    output logic [15:0] Data_in_ins,
    output logic [15:0] Data_in_dram,
    output logic        iram_write_ext,
    output logic        dram_write_ext,
    output logic        start_2,
    output logic        start_3,
    output logic        start,
    output logic        busy,
    output logic        err,
    output logic [15:0] chk_out
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD - 1);

    typedef enum logic [3:0] {
        IDLE, I_WAIT, I_SETUP, I_WRITE, I_HOLD,
        D_WAIT, D_SETUP, D_WRITE, D_HOLD, RUN, ERR
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        last_q;
    logic        fin;
    logic        trl;
    logic [15:0] chk;

    assign chk_out = CHK_EN ? chk : 16'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            addr_ext       <= ADDR_BASE;
            Data_in_ins    <= 16'd0;
            Data_in_dram   <= 16'd0;
            iram_write_ext <= 1'b0;
            dram_write_ext <= 1'b0;
            start_2        <= 1'b0;
            start_3        <= 1'b0;
            start          <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
            in_ready       <= 1'b0;
            cnt            <= 4'd0;
            last_q         <= 1'b0;
            fin            <= 1'b0;
            trl            <= 1'b0;
            chk            <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= I_WAIT;
                        addr_ext <= ADDR_BASE;
                        start_2  <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        chk      <= 16'd0;
                    end
                end
                I_WAIT, D_WAIT: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (CHK_EN && trl) begin
                            // Trailer word: compared against the sum, never written
                            start_3 <= 1'b0;
                            if (in_data == chk) begin
                                state <= D_HOLD;
                                fin   <= 1'b1;
                            end else begin
                                state <= ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            last_q <= in_last;
                            chk    <= chk + in_data;
                            if (state == I_WAIT) begin
                                Data_in_ins <= in_data;
                                state       <= I_SETUP;
                            end else begin
                                Data_in_dram <= in_data;
                                state        <= D_SETUP;
                            end
                        end
                    end
                end
                I_SETUP: begin
                    state          <= I_WRITE;
                    iram_write_ext <= 1'b1;
                    cnt            <= HOLD_LAST;
                end
                D_SETUP: begin
                    state          <= D_WRITE;
                    dram_write_ext <= 1'b1;
                    cnt            <= HOLD_LAST;
                end
                I_WRITE, D_WRITE: begin
                    if (cnt == 4'd0) begin
                        iram_write_ext <= 1'b0;
                        dram_write_ext <= 1'b0;
                        state          <= (state == I_WRITE) ? I_HOLD : D_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                I_HOLD, D_HOLD: begin
                    if (fin) begin
                        // One quiet cycle with both selects low has elapsed
                        fin   <= 1'b0;
                        state <= RUN;
                        start <= 1'b1;
                        busy  <= 1'b0;
                    end else if (last_q) begin
                        if (state == I_HOLD) begin
                            start_2  <= 1'b0;
                            start_3  <= 1'b1;
                            addr_ext <= ADDR_BASE;
                            state    <= D_WAIT;
                            in_ready <= 1'b1;
                        end else if (CHK_EN) begin
                            trl      <= 1'b1;
                            state    <= D_WAIT;
                            in_ready <= 1'b1;
                        end else begin
                            start_3 <= 1'b0;
                            fin     <= 1'b1;
                        end
                    end else if (addr_ext == 9'd511) begin
                        state   <= ERR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        start_2 <= 1'b0;
                        start_3 <= 1'b0;
                    end else begin
                        addr_ext <= addr_ext + 9'd1;
                        in_ready <= 1'b1;
                        state    <= (state == I_HOLD) ? I_WAIT : D_WAIT;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have parameter WR_HOLD, default 4, which sets the number of clock cycles each write-enable pulse is held high (legal 1..15).
REQ-002 The block SHALL have parameter ADDR_BASE, default 9'd1, which sets the first address written in each load phase.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 go  input  1  begins a load sequence; sampled only in IDLE.
REQ-006 in_valid  input  1  in_data/in_last hold a valid word.
REQ-007 in_data  input  16  word to be written.
REQ-008 in_last  input  1  marks the final word of the current phase.
REQ-009 in_ready  output  1  block accepts a word this cycle.
REQ-010 addr_ext  output  9  external IRAM/DRAM write address.
REQ-011 Data_in_ins  output  16  IRAM write data.
REQ-012 Data_in_dram  output  16  DRAM write data.
REQ-013 iram_write_ext  output  1  IRAM write enable.
REQ-014 dram_write_ext  output  1  DRAM write enable.
REQ-015 start_2  output  1  IRAM external-load select.
REQ-016 start_3  output  1  DRAM external-load select.
REQ-017 start  output  1  processor run enable.
REQ-018 busy, err  output  1 each  load in progress / load aborted.
REQ-019 chk_out  output  16  running checksum (see Configuration).

Function
REQ-020 FSM states SHALL be IDLE, I_WAIT, I_SETUP, I_WRITE, I_HOLD, D_WAIT, D_SETUP, D_WRITE, D_HOLD, RUN, ERR.
REQ-021 IDLE with go=1 SHALL enter I_WAIT, with addr_ext=ADDR_BASE and start_2=1.
REQ-022 in_ready SHALL be 1 only in I_WAIT and D_WAIT; a word is accepted on in_valid&in_ready.
REQ-023 On acceptance, the FSM SHALL enter SETUP for exactly 1 cycle, driving the data bus with the word and the write enable low.
REQ-024 WRITE SHALL hold the phase write enable high for exactly WR_HOLD cycles; HOLD SHALL then hold it low for 1 cycle, with address and data stable throughout SETUP/WRITE/HOLD.
REQ-025 On leaving HOLD with the word not marked last, addr_ext SHALL increment by 1 and the FSM SHALL return to WAIT.
REQ-026 On leaving I_HOLD with last, the FSM SHALL: deassert start_2; assert start_3; reset addr_ext to ADDR_BASE; and enter D_WAIT in the same cycle.
REQ-027 On leaving D_HOLD with last, the FSM SHALL: deassert start_3; spend 1 cycle with start_2=start_3=0; then enter RUN.
REQ-028 RUN SHALL hold start=1, and all write enables and in_ready=0, until reset.
REQ-029 Overflow: leaving HOLD at addr_ext=9'd511 without last SHALL enter ERR; address never wraps.
REQ-030 ERR SHALL drive err=1, start=start_2=start_3=0 and in_ready=0, until reset.
REQ-031 busy SHALL be 1 in all states except IDLE, RUN and ERR.
REQ-032 go outside IDLE SHALL be ignored; a word with only in_last set is written normally.
REQ-033 Each phase SHALL write at least one word; per-word latency from acceptance to the next in_ready SHALL be WR_HOLD+2 cycles.

Reset
REQ-034 Reset SHALL force IDLE and all outputs to 0, except addr_ext=ADDR_BASE; reset mid-write SHALL drop the write enable on the next edge.

Configuration
REQ-035 With LOADER_CHECKSUM_EN defined, chk_out SHALL be the 16-bit wrapping sum of all accepted words, cleared on go.
REQ-036 With LOADER_CHECKSUM_EN defined, after the DRAM last word one trailer word SHALL be accepted in D_WAIT and is not written; match with chk_out enters RUN, mismatch enters ERR.
REQ-037 Without LOADER_CHECKSUM_EN, chk_out SHALL be tied to 0, and no trailer is expected.

Verification
REQ-038 IRAM words 10,20,30(last) and DRAM 5(last) -> writes at addresses 1,2,3 and 1 respectively, each enable high 4 cycles, then start=1.
REQ-039 in_valid held low for 20 cycles in I_WAIT -> no write occurs and state is unchanged; the word is accepted on the first in_valid.
REQ-040 511 IRAM words, none last -> 511 writes, then err=1 and start=0.
REQ-041 reset asserted during the 2nd cycle of I_WRITE -> iram_write_ext=0 next cycle and IDLE.
REQ-042 LOADER_CHECKSUM_EN defined, words 1,2 | 3(last), trailer 6 -> RUN; trailer 7 -> ERR.
REQ-043 WR_HOLD=1 -> each enable pulse is 1 cycle wide and the accept-to-next-ready time is 3 cycles.
